// File: rtl/dmem_responder.sv
// Multicycle 16-bit data-memory responder for the MEM stage: one request at a time,
// stall for LATENCY cycles, then commit the store or return load data.
// Optional last-word fast-hit buffer enabled by defining DMEM_RESP_FASTHIT_EN.

module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             rdata_q, rdata_d;

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    mem_we;
    logic                    load_edge;
    logic                    fast_hit;
    logic [15:0]             hit_data;

    logic [15:0]             mem_q [DEPTH];

    assign req_idx = req_addr[DEPTH_LOG2:1];

    generate
        if (DEPTH_LOG2 < 15) begin : g_addr_unused
            logic unused_addr;
            assign unused_addr = ^{req_addr[15:DEPTH_LOG2+1], req_addr[0]};
        end else begin : g_addr_unused_lsb
            logic unused_addr;
            assign unused_addr = req_addr[0];
        end
    endgenerate

    // A store commits at the end of RESP; reset in that same cycle discards it.
    assign mem_we    = (state_q == S_RESP) && wr_q && !rst;
    assign load_edge = (state_q == S_WAIT) && (cnt_q == 4'd0) && !wr_q;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    wr_d    = req_wr;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    if (fast_hit) begin
                        state_d = S_RESP;
                        rdata_d = hit_data;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                // Inputs are deliberately ignored here; the captured request runs to completion.
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (!wr_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- output decode
    always_comb begin
        stall       = 1'b0;
        busy        = (state_q != S_IDLE);
        rdata_valid = 1'b0;
        case (state_q)
            S_IDLE:  stall = req_en;
            S_WAIT:  stall = 1'b1;
            S_RESP:  rdata_valid = !wr_q;
            default: stall = 1'b0;
        endcase
    end

    assign rdata = rdata_q;

`ifdef DMEM_RESP_FASTHIT_EN
    logic                  hit_valid_q, hit_valid_d;
    logic [DEPTH_LOG2-1:0] hit_idx_q, hit_idx_d;
    logic [15:0]           hit_data_q, hit_data_d;

    assign fast_hit = (state_q == S_IDLE) && req_en && !req_wr && hit_valid_q
                      && (hit_idx_q == req_idx);
    assign hit_data = hit_data_q;

    // Slow loads fill the buffer as the array is read; stores refresh it at commit.
    always_comb begin
        hit_valid_d = hit_valid_q;
        hit_idx_d   = hit_idx_q;
        hit_data_d  = hit_data_q;
        if (load_edge) begin
            hit_valid_d = 1'b1;
            hit_idx_d   = idx_q;
            hit_data_d  = mem_q[idx_q];
        end
        if (mem_we) begin
            hit_valid_d = 1'b1;
            hit_idx_d   = idx_q;
            hit_data_d  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            hit_data_q  <= 16'h0000;
        end else begin
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            hit_data_q  <= hit_data_d;
        end
    end
`else
    logic unused_load_edge;
    assign unused_load_edge = load_edge;
    assign fast_hit         = 1'b0;
    assign hit_data         = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-array model plus a queue of expected
// load data, checked against stall/busy/rdata_valid timing. Honours DMEM_RESP_FASTHIT_EN.

module tb_dmem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int LAT        = 4;
    localparam int MAXCYC     = 40;

    logic        clk;
    logic        rst;
    logic        req_en;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        stall;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] model [1 << DEPTH_LOG2];
    logic [15:0] exp_q [$];
    logic [15:0] last_rdata;
    bit          buf_v;
    int          buf_idx;

    dmem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_en     (req_en),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_idx(input logic [15:0] addr);
        logic [DEPTH_LOG2-1:0] w;
        w = addr[DEPTH_LOG2:1];
        return int'(w);
    endfunction

    // One full request; called and returning at posedge+1.
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          input bit perturb, input string name);
        int          idx;
        int          exp_lat;
        int          c;
        bit          done;
        logic [15:0] exp;
        idx     = word_idx(addr);
        exp_lat = LAT;
`ifdef DMEM_RESP_FASTHIT_EN
        if (!wr && buf_v && buf_idx == idx) exp_lat = 1;
`endif
        if (!wr) exp_q.push_back(model[idx]);
        req_en    = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        c         = 0;
        done      = 1'b0;
        while (!done && c < MAXCYC) begin
            @(negedge clk);
            if (c > 0 && !stall) begin
                vectors++;
                if (c != exp_lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d cycles, expected %0d", name, c, exp_lat);
                end
                vectors++;
                if (rdata_valid !== !wr || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s resp flags: rdata_valid=%b busy=%b, expected rdata_valid=%b busy=1",
                             name, rdata_valid, busy, !wr);
                end
                vectors++;
                if (!wr) begin
                    exp = exp_q.pop_front();
                    if (rdata !== exp) begin
                        miscompares++;
                        $display("FAIL %s rdata: got %h, expected %h", name, rdata, exp);
                    end
                    last_rdata = exp;
                end else if (rdata !== last_rdata) begin
                    miscompares++;
                    $display("FAIL %s rdata hold: got %h, expected %h", name, rdata, last_rdata);
                end
                done = 1'b1;
            end else begin
                vectors++;
                if (stall !== 1'b1 || rdata_valid !== 1'b0 || busy !== (c > 0)) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: stall=%b rdata_valid=%b busy=%b, expected 1 0 %b",
                             name, c, stall, rdata_valid, busy, c > 0);
                end
            end
            @(posedge clk);
            #1;
            c++;
            if (perturb && c == 1) begin
                req_en    = 1'b0;
                req_wr    = ~wr;
                req_addr  = addr ^ 16'h0102;
                req_wdata = ~wd;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: no response within %0d cycles, expected %0d", name, MAXCYC, exp_lat);
            if (!wr && exp_q.size() > 0) void'(exp_q.pop_back());
        end
        req_en = 1'b0;
        if (wr) begin
            model[idx] = wd;
            buf_v      = 1'b1;
            buf_idx    = idx;
        end else if (exp_lat != 1) begin
            buf_v   = 1'b1;
            buf_idx = idx;
        end
        @(negedge clk);
        vectors++;
        if (rdata_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle after: rdata_valid=%b busy=%b stall=%b, expected 0 0 0",
                     name, rdata_valid, busy, stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        buf_v      = 1'b0;
        last_rdata = 16'h0000;
        @(negedge clk);
        vectors++;
        if (rdata !== 16'h0000 || rdata_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: rdata=%h rdata_valid=%b busy=%b stall=%b, expected 0000 0 0 0",
                     rdata, rdata_valid, busy, stall);
        end
        @(posedge clk);
        #1;
        // Reset and request together: the request must not be captured.
        rst       = 1'b1;
        req_en    = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h7777;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset+req: busy=%b stall=%b, expected 0 0", busy, stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        access(1'b1, 16'h0010, 16'hBEEF, 1'b0, "store_beef");
        access(1'b0, 16'h0010, 16'h0000, 1'b0, "load_beef");
    endtask

    task automatic test_alias();
        access(1'b1, 16'h0011, 16'h1234, 1'b0, "store_alias");
        access(1'b0, 16'h0810, 16'h0000, 1'b0, "load_alias");
    endtask

    task automatic test_input_hold();
        access(1'b1, 16'h0030, 16'hCAFE, 1'b1, "store_hold");
        access(1'b0, 16'h0010, 16'h0000, 1'b1, "load_hold_a");
        access(1'b0, 16'h0030, 16'h0000, 1'b0, "load_hold_b");
    endtask

    task automatic reset_mid(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                             input string name);
        req_en    = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_en     = 1'b0;
        buf_v      = 1'b0;
        last_rdata = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 16'h0000) begin
                miscompares++;
                $display("FAIL %s: busy=%b stall=%b rdata_valid=%b rdata=%h, expected 0 0 0 0000",
                         name, busy, stall, rdata_valid, rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        access(1'b1, 16'h0020, 16'h5555, 1'b0, "store_old");
        reset_mid(1'b1, 16'h0020, 16'hAAAA, "rst_mid_store");
        access(1'b0, 16'h0020, 16'h0000, 1'b0, "load_after_rst");
        reset_mid(1'b0, 16'h0020, 16'h0000, "rst_mid_load");
        access(1'b0, 16'h0020, 16'h0000, 1'b0, "load_after_rst2");
    endtask

    task automatic test_fast_hit();
        test_reset();
        access(1'b0, 16'h0010, 16'h0000, 1'b0, "hit_first");
        access(1'b0, 16'h0010, 16'h0000, 1'b0, "hit_second");
        test_reset();
        access(1'b0, 16'h0010, 16'h0000, 1'b0, "hit_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 16'hFFFF));
            d = 16'($urandom_range(0, 16'hFFFF));
            access(1'b1, a, d, 1'b0, "b2b_store");
            access(1'b0, a ^ 16'h0801, 16'h0000, 1'b0, "b2b_load");
            access(1'b0, 16'h0030, 16'h0000, 1'b0, "b2b_load_other");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_en     = 1'b0;
        req_wr     = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        buf_v      = 1'b0;
        buf_idx    = 0;
        last_rdata = 16'h0000;
        @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_alias();
        test_input_hold();
        test_reset_mid_op();
        test_fast_hit();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multicycle data-memory responder serving the pipeline's MEM-stage load/store requests. Accepts one request at a time, holds the requester with `stall` for a fixed access latency, then commits the write or returns read data. It replaces the single-cycle data memory and is the responder end of the MEM-stage memory interface, whose initiator is the CPU pipeline.

## Interface
- `DEPTH_LOG2`, 10: storage depth in 16-bit words (1024).
- `LATENCY`, 4: cycles from acceptance to response; legal range 2..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_en` in 1: request present (load or store).
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 16: byte address; bit 0 ignored; word index = `req_addr[DEPTH_LOG2:1]`; upper bits ignored, so addresses alias.
- `req_wdata` in 16: store data.
- `stall` out 1: hold the pipeline; requester keeps its request stable.
- `rdata` out 16: load data, registered.
- `rdata_valid` out 1: one-cycle pulse marking a load response.
- `busy` out 1: FSM not in IDLE (debug/perf).

## Operation
- State machine: IDLE, WAIT, RESP.
- **IDLE**
  - `req_en=1`: capture `req_wr`, word index and `req_wdata` into holding registers. Load `cnt = LATENCY-2`. Go to WAIT.
  - `stall = req_en` (combinational).
- **WAIT**
  - `stall=1`.
  - `cnt==0`: go to RESP. Otherwise decrement `cnt`.
  - On the WAIT→RESP edge, load `rdata` from the array at the captured index, for loads only.
  - Inputs are ignored in WAIT; dropping `req_en` does not cancel the request.
- **RESP**
  - `stall=0`. `rdata_valid = ~captured_wr`.
  - A store writes the array at the end of the RESP cycle.
  - Always returns to IDLE. The requester advances on this edge.
  - `req_en` seen in the following IDLE cycle is a new request.
- **Hazards**
  - A load immediately after a store to the same word returns the stored value.
  - There are no back-to-back pipelined requests: at least one IDLE cycle separates responses.
- **Other rules**
  - `rdata` holds its last load value through stores and idle cycles.
  - The array is not cleared by `rst`; its contents are undefined until written.

## Timing
- Request accepted in cycle 0; response (RESP) in cycle `LATENCY`.
- `stall` is high in cycles 0..`LATENCY-1` and low in cycle `LATENCY`.
- A request therefore costs `LATENCY` stall cycles.
- Reset values: state IDLE, `stall=0` (while `req_en=0`), `rdata=16'h0000`, `rdata_valid=0`, `busy=0`, `cnt=0`, capture registers 0.
- **Reset mid-operation:** go to IDLE on the next edge. A pending store is discarded and is never committed. A pending load produces no `rdata_valid`.
- **Simultaneous reset and request:** reset wins; the request is not captured.
- `stall` depends combinationally on `req_en` in IDLE only; every other output is registered or decoded from state.

## Configuration
- Macro `DMEM_RESP_FASTHIT_EN`.
- **Defined:** adds a one-entry last-word buffer (valid bit, word index, data).
  - Any store updates the buffer at commit.
  - Any slow-path load fills the buffer.
  - A load in IDLE whose index matches a valid entry goes directly to RESP: `stall` lasts 1 cycle and `rdata` comes from the buffer.
  - Stores always take the full `LATENCY`.
  - `rst` clears the valid bit.
- **Undefined:** no buffer; every access takes `LATENCY` cycles.

## Test plan
(`LATENCY=4`)
- **Reset:** hold `rst` 2 cycles → `rdata=0`, `rdata_valid=0`, `busy=0`, `stall=0`.
- **Store then load:**
  - Store `addr=16'h0010`, `wdata=16'hBEEF` → `stall` high 4 cycles, low in cycle 4, no `rdata_valid`.
  - Load `16'h0010` → `rdata_valid` pulse in cycle 4 with `rdata=16'hBEEF`.
- **Alias and bit 0:** store `16'h0011 ← 16'h1234`, then load `16'h0810` (`DEPTH_LOG2=10`) → `rdata=16'h1234`.
- **Input hold:** change `req_addr` and `req_wdata` and drop `req_en` during WAIT → the original request completes unchanged and the response arrives in cycle 4.
- **Reset mid-store:** `rst` in cycle 2 of a store `16'h0020 ← 16'hAAAA`; then load `16'h0020` → old value returned, not `16'hAAAA`.
- **Fast hit (`DMEM_RESP_FASTHIT_EN`):**
  - Load `16'h0010` twice → the second load has `stall` for 1 cycle and `rdata_valid` in cycle 1 with the correct data.
  - After `rst`, the same load takes 4 cycles.
